// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port memory between fetch (IF) and load/store (D) ports.
//   clk, reset (async, active-low)
//   IF port : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   D port  : d_req, d_we, d_addr, d_wdata, d_be -> d_gnt, d_rvalid, d_rdata
//   bus_err : flags the rvalid of a timed-out access
//   memory  : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_ready, mem_rdata
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              idle, pick_if, pick_d, done, abort;
  // Grants are gated by reset so nothing is granted while reset is held.
  assign idle    = state_q == IDLE;
  assign pick_d  = idle && reset && d_req && (!if_req || !last_d_q);
  assign pick_if = idle && reset && if_req && (!d_req || last_d_q);
  assign done    = !idle && mem_ready;
  // The limit is checked one count early so mem_req is high for exactly TIMEOUT cycles.
  assign abort   = !idle && !mem_ready && TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (pick_if || pick_d) begin
      state_d  = pick_d ? BUSY_D : BUSY_IF;
      last_d_d = pick_d;
      cnt_d    = '0;
      we_d     = pick_d && d_we;
      addr_d   = pick_d ? d_addr : if_addr;
      wdata_d  = pick_d ? d_wdata : '0;
      be_d     = pick_d ? d_be : '1;
    end
    if (done || abort) begin
      state_d     = IDLE;
      if_rvalid_d = state_q == BUSY_IF;
      d_rvalid_d  = state_q == BUSY_D;
      bus_err_d   = abort;
      if (state_q == BUSY_IF) if_rdata_d = done ? mem_rdata : '0;
      else d_rdata_d = (done && !we_q) ? mem_rdata : '0;
    end else if (!idle && TIMEOUT != 0) begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign if_gnt    = pick_if;
  assign d_gnt     = pick_d;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = !idle;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [3:0]  d_be = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, bus_err, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [138:0] outs;
  int checks = 0, errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign outs = {if_gnt, d_gnt, if_rvalid, d_rvalid, bus_err, mem_req, mem_we, mem_be,
                 if_rdata, d_rdata, mem_addr, mem_wdata};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[7];

  // One isolated transaction: grant, `waits` stall cycles (>= TO means never ready), then the response.
  task automatic run_txn(input vec_t v);
    tick;
    if_req = !v.is_d; if_addr = v.addr;
    d_req = v.is_d; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    mem_ready = 1'b0;
    #2;
    chk("txn_gnt", {if_gnt, d_gnt}, {!v.is_d, v.is_d});
    for (int w = 0; w < TO; w++) begin
      tick;
      if_req = 1'b0; d_req = 1'b0;
      mem_ready = (w == v.waits);
      mem_rdata = (w == v.waits) ? v.rdata : $urandom;
      #2;
      chk("txn_busy", {mem_req, mem_we, mem_addr, mem_be, if_gnt, d_gnt},
          {1'b1, v.we & v.is_d, v.addr, v.exp_be, 2'b00});
      if (v.is_d) chk("txn_wdata", mem_wdata, v.wdata);
      if (w == v.waits) break;
    end
    tick;
    mem_ready = 1'b0;
    #2;
    chk("txn_resp", {mem_req, if_rvalid, d_rvalid, bus_err}, {1'b0, !v.is_d, v.is_d, v.exp_err});
    chk("txn_rdata", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
  endtask

  // Reference model state: the in-flight transaction plus the expected registered responses.
  logic        m_busy, m_owner, m_last, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_age;
  logic        e_if_rv, e_d_rv, e_err, e_if_g, e_d_g, g_if, g_d;
  logic [31:0] e_if_rd, e_d_rd;
  logic [138:0] exp_v, mask_v;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'h0010_0093, 4'hf, 32'h0010_0093, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 2, 32'h1234_5678, 4'h3, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hf, 1, 32'hCAFE_F00D, 4'hf, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hf, 99, 32'h7777_7777, 4'hf, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0208, 32'h0, 4'hc, TO - 1, 32'hA5A5_5A5A, 4'hc, 32'hA5A5_5A5A, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 99, 32'h3333_3333, 4'hf, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0ABC, 32'h0, 4'h0, 0, 32'h1111_2222, 4'hf, 32'h1111_2222, 1'b0};

    // Reset with both ports requesting: everything quiet, then D wins the first contention.
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h80; d_addr = 32'h40; d_be = 4'hf;
    repeat (2) begin
      tick;
      chk("reset_outs", outs, '0);
    end
    reset = 1'b1;
    #1;
    chk("rel_gnt", {if_gnt, d_gnt}, 2'b01);
    tick;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h55;
    #2;
    chk("rel_busy", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
    tick;
    mem_ready = 1'b0;
    #2;
    chk("rel_resp", {d_rvalid, if_rvalid, bus_err, d_rdata}, {3'b100, 32'h55});

    foreach (vecs[i]) run_txn(vecs[i]);

    // Continuous contention after an IF transaction: D, IF, D, IF with zero-wait memory.
    tick;
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
    mem_ready = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk("cont_gnt", {if_gnt, d_gnt}, {k[0], !k[0]});
      if (k > 0) chk("cont_rv", {if_rvalid, d_rvalid}, {!k[0], k[0]});
      tick;
      if (k == 3) begin if_req = 1'b0; d_req = 1'b0; end
      #2;
      chk("cont_busy", {mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_addr},
          {5'b10000, k[0] ? 32'h1000 : 32'h2000});
      tick;
      #2;
    end
    chk("cont_last_rv", {if_rvalid, d_rvalid}, 2'b10);

    // Reset during the second cycle of a stalled load drops it silently.
    mem_ready = 1'b0;
    tick;
    d_req = 1'b1; d_addr = 32'h300;
    #2;
    chk("mid_gnt", d_gnt, 1'b1);
    tick;
    d_req = 1'b0;
    #2;
    chk("mid_busy1", mem_req, 1'b1);
    tick;
    #2;
    chk("mid_busy2", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_async", mem_req, 1'b0);
    tick;
    #2;
    chk("mid_quiet", {if_rvalid, d_rvalid, bus_err, mem_req}, 4'b0);
    reset = 1'b1;
    tick;
    #2;
    chk("mid_quiet2", {if_rvalid, d_rvalid, bus_err, mem_req}, 4'b0);
    run_txn(vecs[0]);

    // Randomized traffic checked cycle by cycle against the model.
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    m_busy = 0; m_owner = 0; m_last = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_age = 0;
    e_if_rv = 0; e_d_rv = 0; e_err = 0; e_if_rd = '0; e_d_rd = '0; g_if = 0; g_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick;
      if (g_if || !if_req) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
      end else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
      if (g_d || !d_req) begin
        d_req = ($urandom_range(0, 2) == 0);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom;
        d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
      mem_ready = $urandom_range(0, 9) < 3;
      mem_rdata = $urandom;
      e_if_g = !m_busy && if_req && (!d_req || m_last);
      e_d_g = !m_busy && d_req && (!if_req || !m_last);
      #2;
      exp_v = {e_if_g, e_d_g, e_if_rv, e_d_rv, e_err, m_busy, m_we, m_be, e_if_rd, e_d_rd, m_addr, m_wdata};
      mask_v = {6'h3f, m_busy, {4{m_busy}}, {64{1'b1}}, {32{m_busy}}, {32{m_busy && m_owner}}};
      chk("rand", outs & mask_v, exp_v & mask_v);
      e_if_rv = 0; e_d_rv = 0; e_err = 0;
      if (m_busy) begin
        if (mem_ready || m_age + 1 == TO) begin
          if (m_owner) begin
            e_d_rv = 1;
            e_d_rd = (mem_ready && !m_we) ? mem_rdata : 32'h0;
          end else begin
            e_if_rv = 1;
            e_if_rd = mem_ready ? mem_rdata : 32'h0;
          end
          e_err = !mem_ready;
          m_busy = 0;
        end else m_age++;
      end
      if (e_if_g || e_d_g) begin
        m_busy = 1; m_owner = e_d_g; m_last = e_d_g; m_age = 0;
        m_addr = e_d_g ? d_addr : if_addr;
        m_we = e_d_g && d_we;
        m_be = e_d_g ? d_be : 4'hf;
        m_wdata = d_wdata;
      end
      g_if = e_if_g; g_d = e_d_g;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
